// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op and sequencer state encodings
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int AW    = 3;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        READ = 2'b01,
        EXEC = 2'b10,
        WB   = 2'b11
    } state_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 16-bit four-operation ALU (add, sub, and, or)
module alu
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    logic             sub;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH:0]   sum;

    // Subtraction is a + ~b + 1, so carry out doubles as "no borrow".
    assign sub   = (op == OP_SUB);
    assign b_in  = sub ? ~b : b;
    assign sum   = {1'b0, a} + {1'b0, b_in} + {{WIDTH{1'b0}}, sub};
    assign carry = sum[WIDTH];

    always_comb begin
        y = sum[WIDTH-1:0];
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = sum[WIDTH-1:0];
        endcase
    end

endmodule

// File: rtl/regfile8x16.sv
// rtl/regfile8x16.sv - register file, two operand read ports, observe port, one sync write port
module regfile8x16 #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    input  logic [AW-1:0]    dbg_raddr,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2,
    output logic [WIDTH-1:0] dbg_rdata
);

    logic [WIDTH-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1    = mem[raddr1];
    assign rdata2    = mem[raddr2];
    assign dbg_rdata = mem[dbg_raddr];

endmodule

// File: rtl/alu_regfile_seq.sv
// rtl/alu_regfile_seq.sv - four-cycle read/execute/write-back sequencer around alu and regfile
module alu_regfile_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [AW-1:0]    cmd_rd,
    input  logic [AW-1:0]    cmd_rs1,
    input  logic [AW-1:0]    cmd_rs2,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             done
);

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [AW-1:0]    rd_q, rs1_q, rs2_q;
    logic [WIDTH-1:0] opa, opb;
    logic [WIDTH-1:0] rdata1, rdata2;
    logic [WIDTH-1:0] alu_y;
    logic             alu_c;
    logic             accept;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    assign accept = cmd_valid && cmd_ready;

    // Write-back and external load share the single write port; loads only land in IDLE.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        done      = 1'b0;
        we        = 1'b0;
        waddr     = ld_addr;
        wdata     = ld_data;
        case (state)
            IDLE: begin
                cmd_ready = !reset;
                we        = ld_en;
                if (accept) state_nxt = READ;
            end
            READ: state_nxt = EXEC;
            EXEC: state_nxt = WB;
            WB: begin
                done      = !reset;
                we        = 1'b1;
                waddr     = rd_q;
                wdata     = result;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            op_q   <= '0;
            rd_q   <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            cout   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= cmd_op;
                rd_q  <= cmd_rd;
                rs1_q <= cmd_rs1;
                rs2_q <= cmd_rs2;
            end
            if (state == READ) begin
                opa <= rdata1;
                opb <= rdata2;
            end
            // Logic ops report no carry regardless of what the adder produced.
            if (state == EXEC) begin
                result <= alu_y;
                cout   <= (op_q == OP_AND || op_q == OP_OR) ? 1'b0 : alu_c;
            end
        end
    end

    regfile8x16 #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) u_regfile (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .raddr1    (rs1_q),
        .raddr2    (rs2_q),
        .dbg_raddr (dbg_addr),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .dbg_rdata (dbg_data)
    );

    alu u_alu (
        .a     (opa),
        .b     (opb),
        .op    (op_q),
        .y     (alu_y),
        .carry (alu_c)
    );

endmodule

// File: tb/tb_alu_regfile_seq.sv
// tb/tb_alu_regfile_seq.sv - scoreboard bench for alu_regfile_seq
module tb_alu_regfile_seq;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] result;
    logic        cout;
    logic        done;

    typedef struct {
        logic [2:0]  rd;
        logic [15:0] res;
        logic        c;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mdl [8];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    alu_regfile_seq dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rs1   (cmd_rs1),
        .cmd_rs2   (cmd_rs2),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .result    (result),
        .cout      (cout),
        .done      (done)
    );

    function automatic void model_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                                      output logic [15:0] y, output logic c);
        logic [16:0] s;
        case (op)
            2'b00: begin s = {1'b0, a} + {1'b0, b}; y = s[15:0]; c = s[16]; end
            2'b01: begin y = a - b; c = (a >= b); end
            2'b10: begin y = a & b; c = 1'b0; end
            default: begin y = a | b; c = 1'b0; end
        endcase
    endfunction

    task automatic do_load(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        mdl[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    // Returns at the negedge after the accepting edge (DUT in READ).
    task automatic issue_cmd(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic lden, input logic [2:0] la,
                             input logic [15:0] ld);
        int   n;
        exp_t e;
        @(negedge clk);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL issue_timeout: cmd_ready=%b required=1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        ld_en = lden; ld_addr = la; ld_data = ld;
        if (lden) mdl[la] = ld;
        model_alu(op, mdl[rs1], mdl[rs2], e.res, e.c);
        e.rd = rd;
        sb.push_back(e);
        mdl[rd] = e.res;
        @(negedge clk);
        cmd_valid = 1'b0;
        ld_en = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_low: got=%b want=0", cmd_ready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got=%b want=1", cmd_ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got=%b want=0", done); end
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL rst_result: got=%h want=0000", result); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL rst_cout: got=%b want=0", cout); end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            total++; if (dbg_data !== 16'h0000) begin bad++; $display("FAIL rst_reg%0d: got=%h want=0000", i, dbg_data); end
            mdl[i] = 16'h0000;
        end
    endtask

    task automatic test_add;
        int   lat;
        exp_t e;
        do_load(3'd1, 16'h1234);
        do_load(3'd2, 16'h0F0F);
        issue_cmd(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        wait_done(lat);
        e = sb.pop_front();
        total++; if (lat !== 3) begin bad++; $display("FAIL add_latency: got=%0d want=3", lat); end
        total++; if (result !== 16'h2143) begin bad++; $display("FAIL add_result: got=%h want=2143", result); end
        total++; if (cout !== e.c) begin bad++; $display("FAIL add_cout: got=%b want=%b", cout, e.c); end
        dbg_addr = 3'd3;
        #1;
        total++; if (dbg_data === 16'h2143) begin bad++; $display("FAIL add_early_wb: got=%h want=old value", dbg_data); end
        @(negedge clk);
        #1;
        total++; if (dbg_data !== e.res) begin bad++; $display("FAIL add_wb: got=%h want=%h", dbg_data, e.res); end
    endtask

    task automatic test_sub;
        logic [2:0] rd_t  [2] = '{3'd1, 3'd4};
        logic [2:0] rs1_t [2] = '{3'd1, 3'd2};
        int   lat;
        exp_t e;
        do_load(3'd1, 16'h0001);
        do_load(3'd2, 16'h0002);
        for (int k = 0; k < 2; k++) begin
            issue_cmd(OP_SUB, rd_t[k], rs1_t[k], 3'd2, 1'b0, 3'd0, 16'h0);
            wait_done(lat);
            e = sb.pop_front();
            total++; if (lat !== 3) begin bad++; $display("FAIL sub%0d_latency: got=%0d want=3", k, lat); end
            total++; if (result !== e.res) begin bad++; $display("FAIL sub%0d_result: got=%h want=%h", k, result, e.res); end
            total++; if (cout !== e.c) begin bad++; $display("FAIL sub%0d_cout: got=%b want=%b", k, cout, e.c); end
            @(negedge clk);
            dbg_addr = e.rd;
            #1;
            total++; if (dbg_data !== e.res) begin bad++; $display("FAIL sub%0d_wb: got=%h want=%h", k, dbg_data, e.res); end
        end
    endtask

    task automatic test_logic;
        logic [1:0] op_t  [3] = '{2'b10, 2'b11, 2'b00};
        logic [2:0] rs2_t [3] = '{3'd6, 3'd6, 3'd5};
        int   lat;
        exp_t e;
        do_load(3'd5, 16'hFFFF);
        do_load(3'd6, 16'h00F0);
        for (int k = 0; k < 3; k++) begin
            issue_cmd(op_t[k], 3'd7, 3'd5, rs2_t[k], 1'b0, 3'd0, 16'h0);
            wait_done(lat);
            e = sb.pop_front();
            total++; if (result !== e.res) begin bad++; $display("FAIL logic%0d_result: got=%h want=%h", k, result, e.res); end
            total++; if (cout !== e.c) begin bad++; $display("FAIL logic%0d_cout: got=%b want=%b", k, cout, e.c); end
            @(negedge clk);
            dbg_addr = 3'd7;
            #1;
            total++; if (dbg_data !== e.res) begin bad++; $display("FAIL logic%0d_wb: got=%h want=%h", k, dbg_data, e.res); end
        end
    endtask

    task automatic test_back_to_back;
        int   acc[$];
        int   lat;
        exp_t e;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_ADD; cmd_rd = 3'd4; cmd_rs1 = 3'd4; cmd_rs2 = 3'd5;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (done === 1'b1) begin
                e = sb.pop_front();
                total++; if (result !== e.res) begin bad++; $display("FAIL b2b_result: got=%h want=%h", result, e.res); end
                total++; if (cout !== e.c) begin bad++; $display("FAIL b2b_cout: got=%b want=%b", cout, e.c); end
            end
            if (cmd_ready === 1'b1) begin
                acc.push_back(cyc);
                model_alu(OP_ADD, mdl[4], mdl[5], e.res, e.c);
                e.rd = 3'd4;
                sb.push_back(e);
                mdl[4] = e.res;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        wait_done(lat);
        e = sb.pop_front();
        total++; if (result !== e.res) begin bad++; $display("FAIL b2b_last_result: got=%h want=%h", result, e.res); end
        total++; if (acc.size() !== 4) begin bad++; $display("FAIL b2b_count: got=%0d want=4", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            total++; if (acc[i] - acc[i-1] !== 4) begin bad++; $display("FAIL b2b_gap%0d: got=%0d want=4", i, acc[i] - acc[i-1]); end
        end
    endtask

    task automatic test_ld_collisions;
        int   lat;
        exp_t e;
        issue_cmd(OP_OR, 3'd0, 3'd6, 3'd6, 1'b0, 3'd0, 16'h0);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 3'd6; ld_data = 16'h1111;
        @(negedge clk);
        ld_en = 1'b0;
        e = sb.pop_front();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ldexec_done: got=%b want=1", done); end
        total++; if (result !== e.res) begin bad++; $display("FAIL ldexec_result: got=%h want=%h", result, e.res); end
        @(negedge clk);
        dbg_addr = 3'd6;
        #1;
        total++; if (dbg_data !== mdl[6]) begin bad++; $display("FAIL ldexec_ignored: got=%h want=%h", dbg_data, mdl[6]); end
        issue_cmd(OP_ADD, 3'd2, 3'd1, 3'd1, 1'b1, 3'd1, 16'h0005);
        wait_done(lat);
        e = sb.pop_front();
        total++; if (result !== 16'h000A) begin bad++; $display("FAIL ldacc_result: got=%h want=000a", result); end
        total++; if (cout !== e.c) begin bad++; $display("FAIL ldacc_cout: got=%b want=%b", cout, e.c); end
        @(negedge clk);
        dbg_addr = 3'd2;
        #1;
        total++; if (dbg_data !== e.res) begin bad++; $display("FAIL ldacc_wb: got=%h want=%h", dbg_data, e.res); end
    endtask

    task automatic test_reset_midop;
        int seen;
        issue_cmd(OP_ADD, 3'd6, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0);
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready_low: got=%b want=0", cmd_ready); end
        total++; if (result !== 16'h0000) begin bad++; $display("FAIL midrst_result: got=%h want=0000", result); end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready: got=%b want=1", cmd_ready); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_done: got=%0d pulses want=0", seen); end
        dbg_addr = 3'd6;
        #1;
        total++; if (dbg_data !== mdl[6]) begin bad++; $display("FAIL midrst_rd: got=%h want=%h", dbg_data, mdl[6]); end
        dbg_addr = 3'd1;
        #1;
        total++; if (dbg_data !== mdl[1]) begin bad++; $display("FAIL midrst_cleared: got=%h want=%h", dbg_data, mdl[1]); end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rd = 3'd0; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
        ld_en = 1'b0; ld_addr = 3'd0; ld_data = 16'h0; dbg_addr = 3'd0;
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_back_to_back();
        test_ld_collisions();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
